stopwatch_counter: RTL and testbench

- Time-base and BCD digit source for the stopwatch: produces the four MM:SS digits (min_tens, min_ones, sec_tens, sec_ones) consumed by the 7-segment multiplexing display driver.
- Runs on the master clock with an internal prescaler.
- Supports run/pause toggle, synchronous clear, and a manual adjust mode that advances a selected field at 2 Hz.

---
 rtl/stopwatch_pkg.sv | 14 +
 rtl/bcd_mod60.sv | 38 +++
 rtl/stopwatch_counter.sv | 89 ++++++++
 tb/tb_stopwatch_counter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants and state encoding for the stopwatch time base.
// Digits are BCD; tens-of-seconds and tens-of-minutes share the same 0..5 range.
package stopwatch_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [DIGIT_W-1:0] ONES_MAX     = 4'd9;

    typedef enum logic {
        ST_PAUSED  = 1'b0,
        ST_RUNNING = 1'b1
    } run_state_t;

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter 00..59 with synchronous clear and increment.
// carry_out flags an increment taken at 59, so a following stage can chain.
module bcd_mod60
    import stopwatch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               clr,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic               carry_out
);

    logic at_max;

    assign at_max    = (tens == SEC_TENS_MAX) && (ones == ONES_MAX);
    assign carry_out = inc & at_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens <= '0;
            ones <= '0;
        end else if (clr) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            if (ones >= ONES_MAX) begin
                ones <= '0;
                // Any tens value at or above the limit folds back to 0.
                tens <= (tens >= SEC_TENS_MAX) ? '0 : tens + DIGIT_W'(1);
            end else begin
                ones <= ones + DIGIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch time base: prescaler, run/pause state and MM:SS BCD digits.
// Adjust mode steps the selected field at twice per second instead of counting.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int PRESC_W       = 27
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pause_p,
    input  logic               clr_p,
    input  logic               adj,
    input  logic               sel,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic               running
);

    localparam logic [PRESC_W-1:0] SEC_LAST  = PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [PRESC_W-1:0] HALF_LAST = PRESC_W'(TICKS_PER_SEC / 2 - 1);

    logic [PRESC_W-1:0] presc_reg;
    run_state_t         state_reg;
    logic               sec_tick;
    logic               half_tick;
    logic               normal;
    logic               sec_inc;
    logic               min_inc;
    logic               sec_carry;
    logic               min_carry_unused;

    assign sec_tick  = (presc_reg == SEC_LAST);
    assign half_tick = (presc_reg == HALF_LAST) || sec_tick;

    // Uses the current (pre-toggle) state so a pause coinciding with a tick still counts it.
    assign normal  = !adj && (state_reg == ST_RUNNING);
    assign sec_inc = normal ? sec_tick : (adj && sel && half_tick);
    assign min_inc = (normal && sec_carry) || (adj && !sel && half_tick);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg <= '0;
        end else if (pause_p || clr_p) begin
            presc_reg <= '0;
        end else if (sec_tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_PAUSED;
        end else if (pause_p) begin
            case (state_reg)
                ST_PAUSED:  state_reg <= ST_RUNNING;
                ST_RUNNING: state_reg <= ST_PAUSED;
                default:    state_reg <= ST_PAUSED;
            endcase
        end
    end

    assign running = (state_reg == ST_RUNNING);

    bcd_mod60 u_seconds (
        .clk       (clk),
        .rst       (rst),
        .inc       (sec_inc),
        .clr       (clr_p),
        .tens      (sec_tens),
        .ones      (sec_ones),
        .carry_out (sec_carry)
    );

    bcd_mod60 u_minutes (
        .clk       (clk),
        .rst       (rst),
        .inc       (min_inc),
        .clr       (clr_p),
        .tens      (min_tens),
        .ones      (min_ones),
        .carry_out (min_carry_unused)
    );

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed and random stimulus for stopwatch_counter, checked every cycle against
// a reference model that keeps time as a plain count of seconds.
module tb_stopwatch_counter;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause_p = 1'b0;
    logic       clr_p = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;

    int checks = 0;
    int fails  = 0;

    // Reference model: total seconds 0..3599, prescaler phase, run flag.
    int m_time = 0;
    int m_cnt  = 0;
    bit m_run  = 1'b0;

    stopwatch_counter #(
        .TICKS_PER_SEC (T),
        .PRESC_W       (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pause_p  (pause_p),
        .clr_p    (clr_p),
        .adj      (adj),
        .sel      (sel),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .running  (running)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] pack_time(int mm, int ss, bit r);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), r};
    endfunction

    task automatic check(input string tag, input logic [16:0] exp);
        logic [16:0] obs;
        obs = {min_tens, min_ones, sec_tens, sec_ones, running};
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_time = 0;
        m_cnt  = 0;
        m_run  = 1'b0;
    endtask

    task automatic model_step(input bit p, input bit c, input bit a, input bit s);
        bit sec_tick;
        bit half_tick;
        int mm;
        int ss;
        sec_tick  = (m_cnt == T - 1);
        half_tick = (m_cnt == T / 2 - 1) || sec_tick;
        mm = m_time / 60;
        ss = m_time % 60;
        if (c) begin
            m_time = 0;
        end else if (!a && m_run && sec_tick) begin
            m_time = (m_time + 1) % 3600;
        end else if (a && half_tick) begin
            if (s) m_time = mm * 60 + (ss + 1) % 60;
            else   m_time = ((mm + 1) % 60) * 60 + ss;
        end
        m_cnt = (p || c) ? 0 : (m_cnt + 1) % T;
        if (p) m_run = !m_run;
    endtask

    task automatic step(input string tag, input bit p, input bit c, input bit a, input bit s);
        pause_p = p;
        clr_p   = c;
        adj     = a;
        sel     = s;
        @(posedge clk);
        model_step(p, c, a, s);
        #1;
        check(tag, pack_time(m_time / 60, m_time % 60, m_run));
        pause_p = 1'b0;
        clr_p   = 1'b0;
    endtask

    task automatic run(input string tag, input int n, input bit a, input bit s);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, a, s);
    endtask

    initial begin
        bit a_cur;
        bit s_cur;

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset", pack_time(0, 0, 1'b0));
        rst = 1'b0;

        run("idle", 20, 1'b0, 1'b0);
        check("idle_hold", pack_time(0, 0, 1'b0));

        // Run for 61 seconds after a resume
        step("pause_on", 1'b1, 1'b0, 1'b0, 1'b0);
        run("count", 4 * 61, 1'b0, 1'b0);
        check("t_01_01", pack_time(1, 1, 1'b1));

        // Adjust up to 59:59, then one running second wraps to 00:00
        step("clr_a", 1'b0, 1'b1, 1'b1, 1'b0);
        run("adj_min", 118, 1'b1, 1'b0);
        run("adj_sec", 118, 1'b1, 1'b1);
        check("t_59_59", pack_time(59, 59, 1'b1));
        run("wrap", 4, 1'b0, 1'b0);
        check("wrap_00_00", pack_time(0, 0, 1'b1));

        // Seconds adjust wraps without carrying; minutes adjust wraps 59 -> 00
        step("clr_b", 1'b0, 1'b1, 1'b1, 1'b1);
        run("adj_sec58", 116, 1'b1, 1'b1);
        check("t_00_58", pack_time(0, 58, 1'b1));
        run("adj_sec_wrap", 8, 1'b1, 1'b1);
        check("t_00_02", pack_time(0, 2, 1'b1));
        run("adj_min58", 116, 1'b1, 1'b0);
        check("t_58_02", pack_time(58, 2, 1'b1));
        run("adj_min_wrap", 6, 1'b1, 1'b0);
        check("t_01_02", pack_time(1, 2, 1'b1));

        // Pause coinciding with a second tick: increment taken, then paused
        step("clr_c", 1'b0, 1'b1, 1'b1, 1'b1);
        run("adj_to_09", 19, 1'b1, 1'b1);
        check("t_00_09", pack_time(0, 9, 1'b1));
        step("pause_tick", 1'b1, 1'b0, 1'b0, 1'b0);
        check("t_00_10", pack_time(0, 10, 1'b0));
        run("paused_hold", 12, 1'b0, 1'b0);
        check("hold_00_10", pack_time(0, 10, 1'b0));

        // Clear coinciding with a second tick at 12:34 while running
        step("clr_d", 1'b0, 1'b1, 1'b1, 1'b0);
        run("adj_min12", 24, 1'b1, 1'b0);
        run("adj_sec34", 68, 1'b1, 1'b1);
        step("resume", 1'b1, 1'b0, 1'b1, 1'b1);
        run("align", 3, 1'b0, 1'b0);
        check("t_12_34", pack_time(12, 34, 1'b1));
        step("clr_tick", 1'b0, 1'b1, 1'b0, 1'b0);
        check("clr_tick_00", pack_time(0, 0, 1'b1));

        // Asynchronous reset mid-count at 05:07
        step("clr_e", 1'b0, 1'b1, 1'b1, 1'b0);
        run("adj_min05", 10, 1'b1, 1'b0);
        run("adj_sec07", 14, 1'b1, 1'b1);
        run("run_507", 2, 1'b0, 1'b0);
        check("t_05_07", pack_time(5, 7, 1'b1));
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst", pack_time(0, 0, 1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        run("post_rst", 6, 1'b0, 1'b0);
        check("post_rst_hold", pack_time(0, 0, 1'b0));

        // Random pulses and mode changes against the model
        a_cur = 1'b0;
        s_cur = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(19, 0) == 0) a_cur = !a_cur;
            if ($urandom_range(7, 0) == 0)  s_cur = !s_cur;
            step("random", ($urandom_range(15, 0) == 0), ($urandom_range(59, 0) == 0),
                 a_cur, s_cur);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
